// File: rtl/seg7_page_scheduler_pkg.sv
// rtl/seg7_page_scheduler_pkg.sv - register offsets, CTRL fields and rotation states for the page scheduler
package seg7_page_scheduler_pkg;

    localparam logic [7:0] OFS_CTRL    = 8'h0;
    localparam logic [7:0] OFS_DWELL   = 8'h1;
    localparam logic [7:0] OFS_PAGE0_L = 8'h2;
    localparam logic [7:0] OFS_PAGE0_R = 8'h3;
    localparam logic [7:0] OFS_PAGE1_L = 8'h4;
    localparam logic [7:0] OFS_PAGE1_R = 8'h5;
    localparam logic [7:0] OFS_PAGE2_L = 8'h6;
    localparam logic [7:0] OFS_PAGE2_R = 8'h7;
    localparam logic [7:0] OFS_PAGE3_L = 8'h8;
    localparam logic [7:0] OFS_PAGE3_R = 8'h9;
    localparam logic [7:0] OFS_JUMP    = 8'hA;

    localparam int CTRL_ROT_EN     = 0;
    localparam int CTRL_BLANK      = 1;
    localparam int CTRL_BLINK_EN   = 2;
    localparam int CTRL_NPAGES_LSB = 4;
    localparam int CTRL_NPAGES_MSB = 5;

    localparam logic [7:0] DWELL_RESET = 8'd100;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_ADVANCE = 2'd2
    } rotState_t;

endpackage

// File: rtl/seg7_tick_gen.sv
// rtl/seg7_tick_gen.sv - free-running prescaler producing a one-cycle 1 ms tick
module seg7_tick_gen
    import seg7_page_scheduler_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic CLK,
    input  logic RESETN,
    output logic TICK
);

    localparam int CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] prescale;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            prescale <= '0;
        end else if (prescale == LastCnt) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + CntW'(1);
        end
    end

    assign TICK = (prescale == LastCnt);

endmodule

// File: rtl/seg7_page_scheduler.sv
// rtl/seg7_page_scheduler.sv - four-page store with timed rotation, jump, blank and blink for the 7-segment display
module seg7_page_scheduler
    import seg7_page_scheduler_pkg::*;
#(
    parameter logic [7:0] BaseAddr    = 8'hD8,
    parameter int         TICK_DIV    = 100000,
    parameter int         BLINK_TICKS = 250
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic [7:0] DISP_L,
    output logic [7:0] DISP_R,
    output logic       DISP_BLANK,
    output logic [1:0] PAGE_IDX,
    output logic       PAGE_WRAP
);

    localparam int BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

    logic            rotEn, blankEn, blinkEn;
    logic [1:0]      npagesM1;
    logic [7:0]      dwellReg;
    logic [7:0]      pageL [4];
    logic [7:0]      pageR [4];

    logic            tick;
    logic [7:0]      offset;
    logic            inWindow, wrCtrl, wrJump, jumpHit, shrinkHit;

    rotState_t       state, stateNext;
    logic [1:0]      pageIdx, idxNext;
    logic [7:0]      dwellCnt, cntNext;
    logic            wrapReg, wrapNext;

    logic [BlinkW-1:0] blinkCnt;
    logic              blinkOff;

    seg7_tick_gen #(.TICK_DIV(TICK_DIV)) tickGen (
        .CLK    (CLK),
        .RESETN (RESETN),
        .TICK   (tick)
    );

    always_comb begin
        offset    = BUS_ADDR - BaseAddr;
        inWindow  = (BUS_ADDR >= BaseAddr) && (offset <= OFS_JUMP);
        wrCtrl    = BUS_WE && inWindow && (offset == OFS_CTRL);
        wrJump    = BUS_WE && inWindow && (offset == OFS_JUMP);
        jumpHit   = wrJump && (BUS_DATA[1:0] <= npagesM1);
        // Shrinking the page count under the shown page restarts from page 0.
        shrinkHit = wrCtrl && (BUS_DATA[CTRL_NPAGES_MSB:CTRL_NPAGES_LSB] < pageIdx);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rotEn    <= 1'b0;
            blankEn  <= 1'b0;
            blinkEn  <= 1'b0;
            npagesM1 <= 2'd0;
            dwellReg <= DWELL_RESET;
            for (int i = 0; i < 4; i++) begin
                pageL[i] <= 8'h00;
                pageR[i] <= 8'h00;
            end
        end else if (BUS_WE && inWindow) begin
            case (offset)
                OFS_CTRL: begin
                    rotEn    <= BUS_DATA[CTRL_ROT_EN];
                    blankEn  <= BUS_DATA[CTRL_BLANK];
                    blinkEn  <= BUS_DATA[CTRL_BLINK_EN];
                    npagesM1 <= BUS_DATA[CTRL_NPAGES_MSB:CTRL_NPAGES_LSB];
                end
                OFS_DWELL:   dwellReg <= BUS_DATA;
                OFS_PAGE0_L: pageL[0] <= BUS_DATA;
                OFS_PAGE0_R: pageR[0] <= BUS_DATA;
                OFS_PAGE1_L: pageL[1] <= BUS_DATA;
                OFS_PAGE1_R: pageR[1] <= BUS_DATA;
                OFS_PAGE2_L: pageL[2] <= BUS_DATA;
                OFS_PAGE2_R: pageR[2] <= BUS_DATA;
                OFS_PAGE3_L: pageL[3] <= BUS_DATA;
                OFS_PAGE3_R: pageR[3] <= BUS_DATA;
                default: ;
            endcase
        end
    end

    // A valid jump or a shrink overrides whatever the rotation would do this cycle.
    always_comb begin
        stateNext = state;
        idxNext   = pageIdx;
        cntNext   = dwellCnt;
        wrapNext  = 1'b0;
        if (jumpHit || shrinkHit) begin
            idxNext   = jumpHit ? BUS_DATA[1:0] : 2'd0;
            cntNext   = 8'd0;
            stateNext = rotEn ? ST_DWELL : ST_HOLD;
        end else begin
            case (state)
                ST_HOLD: begin
                    cntNext = 8'd0;
                    if (rotEn) begin
                        stateNext = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (!rotEn) begin
                        stateNext = ST_HOLD;
                        cntNext   = 8'd0;
                    end else if (tick && (dwellReg != 8'd0)) begin
                        if (dwellCnt == dwellReg - 8'd1) begin
                            stateNext = ST_ADVANCE;
                        end else begin
                            cntNext = dwellCnt + 8'd1;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (pageIdx == npagesM1) begin
                        idxNext  = 2'd0;
                        wrapNext = 1'b1;
                    end else begin
                        idxNext = pageIdx + 2'd1;
                    end
                    cntNext   = 8'd0;
                    stateNext = ST_DWELL;
                end
                default: begin
                    stateNext = ST_HOLD;
                    cntNext   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= ST_HOLD;
            pageIdx  <= 2'd0;
            dwellCnt <= 8'd0;
            wrapReg  <= 1'b0;
        end else begin
            state    <= stateNext;
            pageIdx  <= idxNext;
            dwellCnt <= cntNext;
            wrapReg  <= wrapNext;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            blinkCnt <= '0;
            blinkOff <= 1'b0;
        end else if (!blinkEn) begin
            blinkCnt <= '0;
            blinkOff <= 1'b0;
        end else if (tick) begin
            if (blinkCnt == BlinkLast) begin
                blinkCnt <= '0;
                blinkOff <= ~blinkOff;
            end else begin
                blinkCnt <= blinkCnt + BlinkW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            DISP_L     <= 8'h00;
            DISP_R     <= 8'h00;
            DISP_BLANK <= 1'b0;
        end else begin
            DISP_L     <= pageL[pageIdx];
            DISP_R     <= pageR[pageIdx];
            DISP_BLANK <= blankEn | (blinkEn & blinkOff);
        end
    end

    assign PAGE_IDX  = pageIdx;
    assign PAGE_WRAP = wrapReg;

endmodule

// File: tb/tb_seg7_page_scheduler.sv
// tb/tb_seg7_page_scheduler.sv - self-checking bench for seg7_page_scheduler
module tb_seg7_page_scheduler;

    localparam int TD = 10;
    localparam int BT = 2;
    localparam logic [7:0] BASE = 8'hD8;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] BUS_DATA = 8'h00;
    logic [7:0] BUS_ADDR = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [7:0] DISP_L, DISP_R;
    logic       DISP_BLANK;
    logic [1:0] PAGE_IDX;
    logic       PAGE_WRAP;

    int checks = 0;
    int errors = 0;

    seg7_page_scheduler #(.BaseAddr(BASE), .TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .BUS_DATA   (BUS_DATA),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_WE     (BUS_WE),
        .DISP_L     (DISP_L),
        .DISP_R     (DISP_R),
        .DISP_BLANK (DISP_BLANK),
        .PAGE_IDX   (PAGE_IDX),
        .PAGE_WRAP  (PAGE_WRAP)
    );

    always #5 CLK = ~CLK;

    // Reference model: page index, ticks spent on the page, pending step.
    int         mCyc, mIdx, mTicks, mNp, mBcnt;
    bit         mAdv, mRunning, mBoff, mRotEn, mBlank, mBlinkEn, mWrap, mDispBlank;
    logic [7:0] mDwell, mDispL, mDispR;
    logic [7:0] mPl [4];
    logic [7:0] mPr [4];

    task automatic mReset();
        mCyc = 0; mIdx = 0; mTicks = 0; mNp = 0; mBcnt = 0;
        mAdv = 0; mRunning = 0; mBoff = 0; mRotEn = 0; mBlank = 0; mBlinkEn = 0;
        mWrap = 0; mDispBlank = 0; mDwell = 8'd100; mDispL = 0; mDispR = 0;
        for (int i = 0; i < 4; i++) begin mPl[i] = 0; mPr[i] = 0; end
    endtask

    task automatic mStep();
        int off, newIdx;
        bit wr, tk, jump, shrink, wrap;
        logic [7:0] d;
        d = BUS_DATA;
        tk = (mCyc % TD) == TD - 1;
        wr = BUS_WE && (BUS_ADDR >= BASE) && (int'(BUS_ADDR) <= int'(BASE) + 10);
        off = int'(BUS_ADDR) - int'(BASE);
        jump = wr && off == 10 && int'(d[1:0]) <= mNp;
        shrink = wr && off == 0 && int'(d[5:4]) < mIdx;
        mDispL = mPl[mIdx];
        mDispR = mPr[mIdx];
        mDispBlank = mBlank | (mBlinkEn & mBoff);
        newIdx = mIdx;
        wrap = 0;
        if (jump || shrink) begin
            newIdx = jump ? int'(d[1:0]) : 0;
            mTicks = 0; mAdv = 0; mRunning = mRotEn;
        end else if (mAdv) begin
            wrap = (mIdx == mNp);
            newIdx = wrap ? 0 : mIdx + 1;
            mAdv = 0; mTicks = 0; mRunning = 1;
        end else if (!mRunning) begin
            mTicks = 0; mRunning = mRotEn;
        end else if (!mRotEn) begin
            mRunning = 0; mTicks = 0;
        end else if (tk && mDwell != 0) begin
            if (mTicks + 1 == int'(mDwell)) begin mAdv = 1; mTicks = 0; end
            else mTicks++;
        end
        if (!mBlinkEn) begin
            mBcnt = 0; mBoff = 0;
        end else if (tk) begin
            if (mBcnt == BT - 1) begin mBcnt = 0; mBoff = !mBoff; end
            else mBcnt++;
        end
        if (wr) begin
            if (off == 0) begin
                mRotEn = d[0]; mBlank = d[1]; mBlinkEn = d[2]; mNp = int'(d[5:4]);
            end else if (off == 1) begin
                mDwell = d;
            end else if (off >= 2 && off <= 9) begin
                if (off % 2 == 0) mPl[(off - 2) / 2] = d;
                else mPr[(off - 2) / 2] = d;
            end
        end
        mIdx = newIdx;
        mWrap = wrap;
        mCyc++;
    endtask

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) mReset();
        else mStep();
    end

    function automatic logic [19:0] modelVec();
        return {mDispL, mDispR, mDispBlank, 2'(mIdx), mWrap};
    endfunction

    // Must be called right after a negedge; returns at the next negedge.
    task automatic busWrite(input logic [7:0] ofs, input logic [7:0] d);
        BUS_WE = 1'b1;
        BUS_ADDR = BASE + ofs;
        BUS_DATA = d;
        @(negedge CLK);
        BUS_WE = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] v;
        @(negedge CLK); @(negedge CLK);
        v = {DISP_L, DISP_R, DISP_BLANK, PAGE_IDX, PAGE_WRAP};
        checks++;
        if (v !== 20'h0) begin errors++; $display("FAIL reset_state got %h exp 00000", v); end
        RESETN = 1'b1;
        @(negedge CLK);
        busWrite(8'h2, 8'h12);
        busWrite(8'h3, 8'h34);
        @(negedge CLK);
        checks++;
        if ({DISP_L, DISP_R} !== 16'h1234) begin errors++; $display("FAIL preload_disp got %h exp 1234", {DISP_L, DISP_R}); end
        @(posedge CLK); #2;
        RESETN = 1'b0;
        #1;
        v = {DISP_L, DISP_R, DISP_BLANK, PAGE_IDX, PAGE_WRAP};
        checks++;
        if (v !== 20'h0) begin errors++; $display("FAIL async_reset got %h exp 00000", v); end
        @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        checks++;
        if ({DISP_L, DISP_R, PAGE_IDX} !== 18'h0) begin errors++; $display("FAIL after_release got %h exp 00000", {DISP_L, DISP_R, PAGE_IDX}); end
    endtask

    task automatic test_rotation();
        logic [7:0] plTab [4];
        int chIdx [4];
        int chCyc [4];
        int nCh, wraps, prevIdx;
        plTab[0] = 8'h11; plTab[1] = 8'h33; plTab[2] = 8'h55; plTab[3] = 8'h00;
        busWrite(8'h2, 8'h11); busWrite(8'h3, 8'h22);
        busWrite(8'h4, 8'h33); busWrite(8'h5, 8'h44);
        busWrite(8'h6, 8'h55); busWrite(8'h7, 8'h66);
        busWrite(8'h1, 8'd2);
        busWrite(8'h0, 8'h21);
        nCh = 0; wraps = 0; prevIdx = int'(PAGE_IDX);
        for (int c = 0; c < 150 && nCh < 4; c++) begin
            @(negedge CLK);
            checks++;
            if ({DISP_L, DISP_R, DISP_BLANK, PAGE_IDX, PAGE_WRAP} !== modelVec()) begin
                errors++; $display("FAIL rot_model got %h exp %h", {DISP_L, DISP_R, DISP_BLANK, PAGE_IDX, PAGE_WRAP}, modelVec());
            end
            checks++;
            if (DISP_L !== plTab[prevIdx]) begin errors++; $display("FAIL rot_disp_lag got %h exp %h", DISP_L, plTab[prevIdx]); end
            if (PAGE_WRAP === 1'b1) wraps++;
            if (int'(PAGE_IDX) != prevIdx) begin
                chIdx[nCh] = int'(PAGE_IDX); chCyc[nCh] = c; nCh++;
            end
            prevIdx = int'(PAGE_IDX);
        end
        checks++;
        if (nCh != 4) begin
            errors++; $display("FAIL rot_steps got %0d exp 4", nCh);
        end else begin
            checks++;
            if (chIdx[0] != 1 || chIdx[1] != 2 || chIdx[2] != 0 || chIdx[3] != 1) begin
                errors++; $display("FAIL rot_order got %0d%0d%0d%0d exp 1201", chIdx[0], chIdx[1], chIdx[2], chIdx[3]);
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (chCyc[k] - chCyc[k-1] != 20) begin errors++; $display("FAIL rot_period got %0d exp 20", chCyc[k] - chCyc[k-1]); end
            end
        end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL rot_wraps got %0d exp 1", wraps); end
    endtask

    task automatic test_jump_collision();
        bit found, stay;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (mIdx == 2 && mRunning && !mAdv && mRotEn && mDwell != 0 &&
                mTicks + 1 == int'(mDwell) && (mCyc % TD) == TD - 1) found = 1;
            else @(negedge CLK);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL jump_wait got timeout exp expiry"); return; end
        busWrite(8'hA, 8'h01);
        checks++;
        if ({PAGE_IDX, PAGE_WRAP} !== 3'b010) begin errors++; $display("FAIL jump_collide got %b exp 010", {PAGE_IDX, PAGE_WRAP}); end
        stay = 1;
        for (int i = 0; i < 21; i++) begin
            @(negedge CLK);
            if (i < 20 && PAGE_IDX !== 2'd1) stay = 0;
        end
        checks++;
        if (!stay) begin errors++; $display("FAIL jump_restart got early exp hold 20"); end
        checks++;
        if (PAGE_IDX !== 2'd2) begin errors++; $display("FAIL jump_next got %0d exp 2", PAGE_IDX); end
        busWrite(8'hA, 8'h03);
        checks++;
        if ({PAGE_IDX, PAGE_WRAP} !== 3'b100) begin errors++; $display("FAIL jump_invalid got %b exp 100", {PAGE_IDX, PAGE_WRAP}); end
    endtask

    task automatic test_shrink();
        busWrite(8'h0, 8'h31);
        busWrite(8'hA, 8'h03);
        checks++;
        if (PAGE_IDX !== 2'd3) begin errors++; $display("FAIL shrink_setup got %0d exp 3", PAGE_IDX); end
        busWrite(8'h0, 8'h11);
        checks++;
        if ({PAGE_IDX, PAGE_WRAP} !== 3'b000) begin errors++; $display("FAIL shrink got %b exp 000", {PAGE_IDX, PAGE_WRAP}); end
    endtask

    task automatic test_blink_blank();
        int tog [8];
        int nTog;
        logic prevB;
        bit ok;
        logic [1:0] idx0;
        busWrite(8'h0, 8'h04);
        nTog = 0; prevB = DISP_BLANK;
        for (int c = 0; c < 130; c++) begin
            @(negedge CLK);
            checks++;
            if (DISP_BLANK !== mDispBlank) begin errors++; $display("FAIL blink_model got %b exp %b", DISP_BLANK, mDispBlank); end
            if (DISP_BLANK !== prevB && nTog < 8) begin tog[nTog] = c; nTog++; end
            prevB = DISP_BLANK;
        end
        checks++;
        if (nTog < 5) begin
            errors++; $display("FAIL blink_toggles got %0d exp >=5", nTog);
        end else begin
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (tog[k] - tog[k-1] != 20) begin errors++; $display("FAIL blink_period got %0d exp 20", tog[k] - tog[k-1]); end
            end
        end
        busWrite(8'h0, 8'h06);
        @(negedge CLK);
        ok = 1;
        for (int c = 0; c < 60; c++) begin
            if (DISP_BLANK !== 1'b1) ok = 0;
            @(negedge CLK);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL blank_hold got 0 exp 1"); end
        busWrite(8'h0, 8'h00);
        busWrite(8'h1, 8'h00);
        busWrite(8'h0, 8'h31);
        idx0 = PAGE_IDX;
        ok = 1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            if (PAGE_IDX !== idx0) ok = 0;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL dwell_zero got %0d exp %0d", PAGE_IDX, idx0); end
    endtask

    task automatic test_live_update();
        logic [15:0] held;
        busWrite(8'h0, 8'h30);
        busWrite(8'hA, 8'h02);
        @(negedge CLK);
        busWrite(8'h7, 8'hA5);
        checks++;
        if (DISP_R !== 8'h66) begin errors++; $display("FAIL live_early got %h exp 66", DISP_R); end
        @(negedge CLK);
        checks++;
        if (DISP_R !== 8'hA5) begin errors++; $display("FAIL live_update got %h exp a5", DISP_R); end
        held = {DISP_L, DISP_R};
        busWrite(8'h4, 8'($urandom_range(0, 255)));
        @(negedge CLK); @(negedge CLK);
        checks++;
        if ({DISP_L, DISP_R} !== held) begin errors++; $display("FAIL other_page got %h exp %h", {DISP_L, DISP_R}, held); end
    endtask

    task automatic test_random();
        int r, o;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            checks++;
            if ({DISP_L, DISP_R, DISP_BLANK, PAGE_IDX, PAGE_WRAP} !== modelVec()) begin
                errors++; $display("FAIL random_model cyc %0d got %h exp %h", c, {DISP_L, DISP_R, DISP_BLANK, PAGE_IDX, PAGE_WRAP}, modelVec());
            end
            r = int'($urandom_range(0, 299));
            if (r == 0) begin
                BUS_WE = 1'b0;
                #2 RESETN = 1'b0;
                #1 RESETN = 1'b1;
            end else if (r < 100) begin
                o = int'($urandom_range(0, 14)) - 2;
                BUS_WE = 1'b1;
                BUS_ADDR = BASE + 8'(o);
                BUS_DATA = (o == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            end else begin
                BUS_WE = 1'b0;
                BUS_ADDR = 8'($urandom_range(0, 255));
                BUS_DATA = 8'($urandom_range(0, 255));
            end
        end
        BUS_WE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_jump_collision();
        test_shrink();
        test_blink_blank();
        test_live_update();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
